// File: rtl/axis_scope_pkg.sv
// Shared types for the scope read-back path: FSM states and skid depth.
package axis_scope_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Skid entries; also the read credit limit (in-flight + buffered).
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_scope_reader_if.sv
// AXI4-Stream bundle carrying read-out samples to the DMA/host sink.
interface axis_scope_reader_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_scope_skid.sv
// 2-entry fall-through skid FIFO. When empty, incoming data bypasses straight
// to the output; anything not taken is held so the output stays stable under
// backpressure. occ feeds the reader's read-credit check.
module axis_scope_skid
  import axis_scope_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;
  logic         empty, push, pop;

  assign empty     = (cnt == 2'd0);
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  // Store only what the sink does not take in bypass this cycle.
  assign push      = in_valid && !(empty && out_ready);
  assign pop       = !empty && out_ready;
  assign occ       = cnt;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/axis_scope_reader.sv
// Reads a completed circular capture buffer out of BRAM oldest-first and
// streams it as AXI4-Stream with tlast on the final word.
// Optional feature macro: SCOPE_READER_ABORT_EN adds abort_flag, which stops
// further reads and closes the stream on the last already-issued word.
module axis_scope_reader
  import axis_scope_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 12
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       start_flag,
`ifdef SCOPE_READER_ABORT_EN
  input  logic                       abort_flag,
`endif
  input  logic [BRAM_ADDR_WIDTH-1:0] trg_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0] pre_data,
  input  logic [BRAM_ADDR_WIDTH-1:0] tot_data,
  output logic                       busy,
  output logic                       bram_porta_clk,
  output logic                       bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
  axis_scope_reader_if.master        m_axis
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_X = {{AW{1'b0}}, 1'b1};

  state_t        state;
  logic [AW-1:0] tot_l;      // latched last buffer address
  logic [AW-1:0] addr;       // address being read this cycle when issue=1
  logic [AW:0]   issue_cnt;  // reads issued so far (0..N)
  logic [AW:0]   last_idx;   // beat index that carries tlast
  logic [AW-1:0] beat_cnt;   // beats accepted so far
  logic          rd_vld;     // BRAM data for last cycle's issue is on rddata

  logic [AW:0]   trg_x, pre_x, tot_x, start_x;
  logic [AW-1:0] addr_next;
  logic [1:0]    outstanding;
  logic          credit_ok, issue, fire, abort_now;
  logic [AW:0]   last_eff;
  logic [1:0]    occ;

  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = areset;
  assign bram_porta_addr = addr;

`ifdef SCOPE_READER_ABORT_EN
  assign abort_now = abort_flag && (state == ST_READ);
`else
  assign abort_now = 1'b0;
`endif

  // Oldest sample sits pre_data entries behind the trigger, modulo depth.
  always_comb begin
    trg_x   = {1'b0, trg_addr};
    pre_x   = {1'b0, pre_data};
    tot_x   = {1'b0, tot_data};
    start_x = (trg_x >= pre_x) ? (trg_x - pre_x) : (trg_x + tot_x + ONE_X - pre_x);
  end

  // Issue a read only while the skid can absorb every word still owed to it.
  always_comb begin
    outstanding = {1'b0, rd_vld} + occ;
    credit_ok   = int'(outstanding) < SKID_DEPTH;
    issue       = (state == ST_READ) && credit_ok && !abort_now;
    addr_next   = (addr == tot_l) ? '0 : addr + ONE_A;
    fire        = m_axis.tvalid && m_axis.tready;
    // An abort truncates the stream to what has already been issued.
    last_eff    = abort_now ? (issue_cnt - ONE_X) : last_idx;
  end

  assign m_axis.tlast = m_axis.tvalid && ({1'b0, beat_cnt} == last_eff);

  // Read-out FSM with address, issue and beat counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      tot_l     <= '0;
      addr      <= '0;
      issue_cnt <= '0;
      last_idx  <= '0;
      beat_cnt  <= '0;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        addr      <= addr_next;
        issue_cnt <= issue_cnt + ONE_X;
      end
      if (fire) beat_cnt <= beat_cnt + ONE_A;

      case (state)
        ST_IDLE: begin
          if (start_flag) begin
            tot_l     <= tot_data;
            addr      <= start_x[AW-1:0];
            issue_cnt <= '0;
            beat_cnt  <= '0;
            last_idx  <= {1'b0, tot_data};
            busy      <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          if (abort_now) begin
            if (issue_cnt == '0 || (fire && m_axis.tlast)) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              last_idx <= issue_cnt - ONE_X;
              state    <= ST_DRAIN;
            end
          end else if (issue && issue_cnt == {1'b0, tot_l}) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fire && m_axis.tlast) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  axis_scope_skid #(.W(AXIS_TDATA_WIDTH)) u_skid (
    .clk       (aclk),
    .rst       (areset),
    .in_valid  (rd_vld),
    .in_data   (bram_porta_rddata),
    .out_valid (m_axis.tvalid),
    .out_data  (m_axis.tdata),
    .out_ready (m_axis.tready),
    .occ       (occ)
  );

endmodule

// File: tb/tb_axis_scope_reader.sv
// Directed bench for axis_scope_reader with AW=4 and a registered BRAM model.
module tb_axis_scope_reader;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start_flag;
  logic [AW-1:0] trg_addr, pre_data, tot_data;
  logic          busy, bram_clk, bram_rst;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rddata;

  axis_scope_reader_if #(.W(DW)) axis ();

  axis_scope_reader #(
    .AXIS_TDATA_WIDTH(DW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .start_flag        (start_flag),
    .trg_addr          (trg_addr),
    .pre_data          (pre_data),
    .tot_data          (tot_data),
    .busy              (busy),
    .bram_porta_clk    (bram_clk),
    .bram_porta_rst    (bram_rst),
    .bram_porta_addr   (bram_addr),
    .bram_porta_rddata (bram_rddata),
    .m_axis            (axis)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {16'hC0DE, 12'h0A0, a};
  endfunction

  // Synchronous-read BRAM: data one cycle after address.
  always @(posedge bram_clk) bram_rddata <= dat(bram_addr);

  typedef struct {
    logic [AW-1:0] tot, trg, pre, exp_s;
    bit            stall;
  } vec_t;

  int tests = 0;
  int errs  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full read-out; caller is positioned just after a negedge.
  // hold keeps start_flag high and moves trg_addr to trg2 mid-run.
  task automatic run(input vec_t v, input bit hold, input logic [AW-1:0] trg2);
    int k = 0, cyc = 0, n;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] ea;
    n = int'(v.tot) + 1;
    tot_data = v.tot; trg_addr = v.trg; pre_data = v.pre;
    start_flag = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    if (!hold) start_flag = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("tvalid_cycle1", {31'b0, axis.tvalid}, 32'd0);
    while (k < n && cyc < 400) begin
      @(negedge aclk);
      cyc++;
      axis.tready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 1 && !v.stall) chk("first_tvalid_latency", {31'b0, axis.tvalid}, 32'd1);
      if (hold && k == 3) trg_addr = trg2;
      if (bram_addr > v.tot) chk("addr_in_range", {28'b0, bram_addr}, {28'b0, v.tot});
      if (prev_stall) begin
        chk("stall_tvalid_hold", {31'b0, axis.tvalid}, 32'd1);
        chk("stall_tdata_hold", axis.tdata, prev_data);
      end
      if (axis.tvalid && axis.tready) begin
        ea = AW'((int'(v.exp_s) + k) % n);
        chk("beat_data", axis.tdata, dat(ea));
        chk("beat_tlast", {31'b0, axis.tlast}, {31'b0, (k == n - 1)});
        chk("beat_busy", {31'b0, busy}, 32'd1);
        k++;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
    end
    if (k < n) chk("beat_timeout", k, n);
    @(negedge aclk);
    axis.tready = 1'b1;
    chk("busy_after_last", {31'b0, busy}, 32'd0);
    chk("tvalid_after_last", {31'b0, axis.tvalid}, 32'd0);
    if (!hold) begin
      @(negedge aclk);
      chk("no_extra_beat", {31'b0, axis.tvalid}, 32'd0);
    end
  endtask

  vec_t vecs[7];
  vec_t v1, v2;

  initial begin
    // tot, trg, pre, expected start, stall
    vecs[0] = '{4'd15, 4'd3,  4'd5,  4'd14, 1'b0};
    vecs[1] = '{4'd9,  4'd2,  4'd4,  4'd8,  1'b0};
    vecs[2] = '{4'd15, 4'd3,  4'd5,  4'd14, 1'b1};
    vecs[3] = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b0};
    vecs[4] = '{4'd7,  4'd7,  4'd0,  4'd7,  1'b0};
    vecs[5] = '{4'd15, 4'd0,  4'd15, 4'd1,  1'b0};
    vecs[6] = '{4'd12, 4'd5,  4'd12, 4'd6,  1'b1};

    areset = 1'b1; start_flag = 1'b0; axis.tready = 1'b1;
    trg_addr = '0; pre_data = '0; tot_data = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy",   {31'b0, busy},         32'd0);
    chk("rst_tvalid", {31'b0, axis.tvalid},  32'd0);
    chk("rst_tlast",  {31'b0, axis.tlast},   32'd0);
    chk("rst_addr",   {28'b0, bram_addr},    32'd0);
    areset = 1'b0;
    @(negedge aclk);

    for (int i = 0; i < 7; i++) run(vecs[i], 1'b0, '0);

    // start_flag held: first run uses latched trg=3, the restart picks up trg=7.
    v1 = '{4'd15, 4'd3, 4'd5, 4'd14, 1'b0};
    v2 = '{4'd15, 4'd7, 4'd5, 4'd2,  1'b0};
    run(v1, 1'b1, 4'd7);
    run(v2, 1'b0, '0);

    // Reset on the 5th beat of a 16-word read-out, then a clean restart.
    begin
      int beats = 0, cyc = 0;
      tot_data = 4'd15; trg_addr = 4'd3; pre_data = 4'd5;
      start_flag = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      start_flag = 1'b0;
      while (beats < 5 && cyc < 50) begin
        @(negedge aclk);
        cyc++;
        if (axis.tvalid && axis.tready) beats++;
      end
      chk("pre_reset_beats", beats, 5);
      areset = 1'b1;
      @(negedge aclk);
      chk("mid_rst_tvalid", {31'b0, axis.tvalid}, 32'd0);
      chk("mid_rst_busy",   {31'b0, busy},        32'd0);
      chk("mid_rst_tlast",  {31'b0, axis.tlast},  32'd0);
      areset = 1'b0;
      @(negedge aclk);
      chk("post_rst_idle", {31'b0, axis.tvalid}, 32'd0);
    end
    run(vecs[0], 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
